calc_sequencer: RTL and testbench

- Keypad-driven controller for the calculator datapath.
- Accumulates decimal operands from key events, then loads op1/op2/operation into the mini ALU.
- Issues a start pulse, waits for completion with a timeout, and latches the result.
- Presents either the current entry or the result, plus an error flag, to the display encoder.

---
 rtl/calc_pkg.sv | 40 ++++
 rtl/calc_digit_accum.sv | 62 ++++++
 rtl/calc_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_calc_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator keypad sequencer: key codes,
// ALU operation codes and controller states.
package calc_pkg;

   localparam logic [3:0] KEY_ADD = 4'd10;
   localparam logic [3:0] KEY_SUB = 4'd11;
   localparam logic [3:0] KEY_MUL = 4'd12;
   localparam logic [3:0] KEY_DIV = 4'd13;
   localparam logic [3:0] KEY_EQ  = 4'd14;
   localparam logic [3:0] KEY_CLR = 4'd15;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      ST_ENTER1 = 3'd0,
      ST_ENTER2 = 3'd1,
      ST_EXEC   = 3'd2,
      ST_RESULT = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

   function automatic logic is_op(input logic [3:0] code);
      return (code >= KEY_ADD) && (code <= KEY_DIV);
   endfunction

   // Op keys 10..13 map onto operation codes 0..3 (modulo-4 subtract).
   function automatic op_t key_to_op(input logic [3:0] code);
      return op_t'(code[1:0] - 2'd2);
   endfunction

endpackage

// File: rtl/calc_digit_accum.sv
// Decimal operand accumulator: acc*10+digit with silent drop of any digit
// that would overflow DATA_W, plus a flag recording that a digit was keyed.
module calc_digit_accum
   import calc_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              seed,
   input  logic              add_digit,
   input  logic [3:0]        digit,
   output logic [DATA_W-1:0] acc,
   output logic              entered
);

   localparam int EXT_W = DATA_W + 4;
   localparam logic [EXT_W-1:0] ACC_MAX = {4'b0000, {DATA_W{1'b1}}};

   logic [DATA_W-1:0] acc_reg;
   logic [DATA_W-1:0] acc_next;
   logic              entered_reg;
   logic              entered_next;
   logic [EXT_W-1:0]  acc_ext;
   logic [EXT_W-1:0]  acc_mac;

   assign acc_ext = {4'b0000, acc_reg};
   assign acc_mac = acc_ext * EXT_W'(10) + EXT_W'(digit);

   always_comb begin
      acc_next     = acc_reg;
      entered_next = entered_reg;
      if (clr) begin
         acc_next     = '0;
         entered_next = 1'b0;
      end else if (seed) begin
         acc_next     = DATA_W'(digit);
         entered_next = 1'b1;
      end else if (add_digit) begin
         entered_next = 1'b1;
         // An overflowing digit is simply discarded; the operand stays as it was.
         if (acc_mac <= ACC_MAX) begin
            acc_next = acc_mac[DATA_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg     <= '0;
         entered_reg <= 1'b0;
      end else begin
         acc_reg     <= acc_next;
         entered_reg <= entered_next;
      end
   end

   assign acc     = acc_reg;
   assign entered = entered_reg;

endmodule

// File: rtl/calc_sequencer.sv
// Keypad-driven controller: builds two decimal operands, launches the ALU,
// waits for completion with a timeout and drives the display encoder.
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int RES_W       = 16,
   parameter int ALU_TIMEOUT = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_valid,
   input  logic [3:0]        key_code,
   output logic [DATA_W-1:0] op1,
   output logic [DATA_W-1:0] op2,
   output logic [1:0]        operation,
   output logic              alu_start,
   input  logic              alu_done,
   input  logic [RES_W-1:0]  alu_result,
   input  logic              alu_sign,
   output logic [RES_W-1:0]  disp_value,
   output logic              disp_sign,
   output logic              disp_err,
   output logic              busy
);

   localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);

   state_t            state_reg, state_next;
   logic [DATA_W-1:0] op1_reg, op1_next;
   logic [DATA_W-1:0] op2_reg, op2_next;
   op_t               operation_reg, operation_next;
   logic              alu_start_reg, alu_start_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [RES_W-1:0]  res_value_reg, res_value_next;
   logic              res_sign_reg, res_sign_next;

   logic              acc_clr;
   logic              acc_seed;
   logic              acc_add;
   logic [DATA_W-1:0] acc;
   logic              entered;

   logic              key_clr;
   logic              key_dig;
   logic              key_opr;
   logic              key_eq;
   logic              res_fits;

   assign key_clr  = key_valid && (key_code == KEY_CLR);
   assign key_dig  = key_valid && is_digit(key_code);
   assign key_opr  = key_valid && is_op(key_code);
   assign key_eq   = key_valid && (key_code == KEY_EQ);
   // A result can only seed a chained calculation if it is a valid operand.
   assign res_fits = !res_sign_reg && (res_value_reg[RES_W-1:DATA_W] == '0);

   calc_digit_accum #(
      .DATA_W (DATA_W)
   ) u_accum (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (acc_clr),
      .seed      (acc_seed),
      .add_digit (acc_add),
      .digit     (key_code),
      .acc       (acc),
      .entered   (entered)
   );

   always_comb begin
      state_next     = state_reg;
      op1_next       = op1_reg;
      op2_next       = op2_reg;
      operation_next = operation_reg;
      alu_start_next = 1'b0;
      cnt_next       = cnt_reg;
      res_value_next = res_value_reg;
      res_sign_next  = res_sign_reg;
      acc_clr        = 1'b0;
      acc_seed       = 1'b0;
      acc_add        = 1'b0;

      if (key_clr) begin
         state_next     = ST_ENTER1;
         op1_next       = '0;
         op2_next       = '0;
         operation_next = OP_ADD;
         res_value_next = '0;
         res_sign_next  = 1'b0;
         acc_clr        = 1'b1;
      end else begin
         case (state_reg)
            ST_ENTER1: begin
               if (key_dig) begin
                  acc_add = 1'b1;
               end else if (key_opr) begin
                  op1_next       = acc;
                  operation_next = key_to_op(key_code);
                  acc_clr        = 1'b1;
                  state_next     = ST_ENTER2;
               end
            end
            ST_ENTER2: begin
               if (key_dig) begin
                  acc_add = 1'b1;
               end else if (key_opr && !entered) begin
                  operation_next = key_to_op(key_code);
               end else if (key_eq && entered) begin
                  op2_next = acc;
                  if (operation_reg == OP_DIV && acc == '0) begin
                     state_next = ST_ERROR;
                  end else begin
                     state_next     = ST_EXEC;
                     alu_start_next = 1'b1;
                     cnt_next       = '0;
                  end
               end
            end
            ST_EXEC: begin
               // alu_done takes priority over a timeout landing in the same cycle.
               if (alu_done) begin
                  res_value_next = alu_result;
                  res_sign_next  = alu_sign;
                  state_next     = ST_RESULT;
               end else if (cnt_reg == CNT_W'(ALU_TIMEOUT)) begin
                  state_next = ST_ERROR;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            ST_RESULT: begin
               if (key_dig) begin
                  acc_seed   = 1'b1;
                  state_next = ST_ENTER1;
               end else if (key_opr) begin
                  if (res_fits) begin
                     op1_next       = res_value_reg[DATA_W-1:0];
                     operation_next = key_to_op(key_code);
                     acc_clr        = 1'b1;
                     state_next     = ST_ENTER2;
                  end else begin
                     state_next = ST_ERROR;
                  end
               end
            end
            ST_ERROR: begin
               state_next = ST_ERROR;
            end
            default: begin
               state_next = ST_ENTER1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_ENTER1;
         op1_reg       <= '0;
         op2_reg       <= '0;
         operation_reg <= OP_ADD;
         alu_start_reg <= 1'b0;
         cnt_reg       <= '0;
         res_value_reg <= '0;
         res_sign_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         op1_reg       <= op1_next;
         op2_reg       <= op2_next;
         operation_reg <= operation_next;
         alu_start_reg <= alu_start_next;
         cnt_reg       <= cnt_next;
         res_value_reg <= res_value_next;
         res_sign_reg  <= res_sign_next;
      end
   end

   // Display shows the operand being keyed until a result exists.
   always_comb begin
      disp_value = '0;
      case (state_reg)
         ST_ENTER1, ST_ENTER2, ST_EXEC: disp_value = RES_W'(acc);
         ST_RESULT:                     disp_value = res_value_reg;
         default:                       disp_value = '0;
      endcase
   end

   assign disp_sign = (state_reg == ST_RESULT) && res_sign_reg;
   assign disp_err  = (state_reg == ST_ERROR);
   assign busy      = (state_reg == ST_EXEC);
   assign alu_start = alu_start_reg;
   assign op1       = op1_reg;
   assign op2       = op2_reg;
   assign operation = operation_reg;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed scenarios plus random
// key sequences compared against a calculator-level reference model.
module tb_calc_sequencer;

   localparam int P_E1  = 0;
   localparam int P_E2  = 1;
   localparam int P_EX  = 2;
   localparam int P_RES = 3;
   localparam int P_ERR = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [7:0]  op1;
   logic [7:0]  op2;
   logic [1:0]  operation;
   logic        alu_start;
   logic        alu_done;
   logic [15:0] alu_result;
   logic        alu_sign;
   logic [15:0] disp_value;
   logic        disp_sign;
   logic        disp_err;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int start_count = 0;

   // reference model of the calculator
   int m_phase, m_acc, m_entered, m_op1, m_op2, m_oper, m_res, m_sign;

   calc_sequencer #(
      .DATA_W      (8),
      .RES_W       (16),
      .ALU_TIMEOUT (32)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .op1        (op1),
      .op2        (op2),
      .operation  (operation),
      .alu_start  (alu_start),
      .alu_done   (alu_done),
      .alu_result (alu_result),
      .alu_sign   (alu_sign),
      .disp_value (disp_value),
      .disp_sign  (disp_sign),
      .disp_err   (disp_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (alu_start === 1'b1) start_count++;
   end

   task automatic press(input logic [3:0] k);
      @(posedge clk); #1;
      key_valid = 1'b1;
      key_code  = k;
      @(posedge clk); #1;
      key_valid = 1'b0;
      key_code  = 4'd0;
   endtask

   // Called in EXEC cycle 0; asserts alu_done in EXEC cycle 'delay'.
   task automatic alu_respond(input int delay, input logic [15:0] r, input logic s);
      repeat (delay) @(posedge clk);
      #1;
      alu_done   = 1'b1;
      alu_result = r;
      alu_sign   = s;
      @(posedge clk); #1;
      alu_done   = 1'b0;
      alu_result = 16'd0;
      alu_sign   = 1'b0;
   endtask

   task automatic m_key(input int k);
      if (k == 15) begin
         m_phase = P_E1; m_acc = 0; m_entered = 0; m_op1 = 0; m_op2 = 0;
         m_oper = 0; m_res = 0; m_sign = 0;
         return;
      end
      case (m_phase)
         P_E1, P_E2: begin
            if (k <= 9) begin
               if (m_acc * 10 + k <= 255) m_acc = m_acc * 10 + k;
               m_entered = 1;
            end else if (k <= 13 && m_phase == P_E1) begin
               m_op1 = m_acc; m_oper = k - 10; m_acc = 0; m_entered = 0; m_phase = P_E2;
            end else if (k <= 13 && m_entered == 0) begin
               m_oper = k - 10;
            end else if (k == 14 && m_phase == P_E2 && m_entered == 1) begin
               m_op2 = m_acc;
               m_phase = (m_oper == 3 && m_acc == 0) ? P_ERR : P_EX;
            end
         end
         P_RES: begin
            if (k <= 9) begin
               m_acc = k; m_entered = 1; m_phase = P_E1;
            end else if (k <= 13) begin
               if (m_sign == 0 && m_res <= 255) begin
                  m_op1 = m_res; m_oper = k - 10; m_acc = 0; m_entered = 0; m_phase = P_E2;
               end else begin
                  m_phase = P_ERR;
               end
            end
         end
         default: ;
      endcase
   endtask

   task automatic m_compute();
      case (m_oper)
         0: begin m_res = m_op1 + m_op2; m_sign = 0; end
         1: begin
            if (m_op1 >= m_op2) begin m_res = m_op1 - m_op2; m_sign = 0; end
            else begin m_res = m_op2 - m_op1; m_sign = 1; end
         end
         2: begin m_res = m_op1 * m_op2; m_sign = 0; end
         default: begin m_res = m_op1 / m_op2; m_sign = 0; end
      endcase
   endtask

   task automatic test_reset();
      rst_n = 1'b0; key_valid = 1'b0; key_code = 4'd0;
      alu_done = 1'b0; alu_result = 16'd0; alu_sign = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({op1, op2, operation, alu_start, disp_value, disp_sign, disp_err, busy} !== 37'd0) begin
         errors++;
         $display("FAIL reset_outputs: got op1=%0d op2=%0d op=%0d start=%0b disp=%0d sign=%0b err=%0b busy=%0b expected all 0",
                  op1, op2, operation, alu_start, disp_value, disp_sign, disp_err, busy);
      end
      rst_n = 1'b1;
      press(4'd7);
      checks++;
      if (disp_value !== 16'd7) begin
         errors++; $display("FAIL reset_enter1: got disp=%0d expected 7", disp_value);
      end
      press(4'd15);
      $display("test_reset done");
   endtask

   task automatic test_basic_add_and_chain();
      int s0;
      press(4'd1); press(4'd2);
      checks++;
      if (disp_value !== 16'd12) begin
         errors++; $display("FAIL entry_12: got %0d expected 12", disp_value);
      end
      press(4'd10);
      checks++;
      if (op1 !== 8'd12 || operation !== 2'b00 || disp_value !== 16'd0) begin
         errors++; $display("FAIL op_key: got op1=%0d op=%0d disp=%0d expected 12 0 0", op1, operation, disp_value);
      end
      press(4'd3); press(4'd4);
      s0 = start_count;
      press(4'd14);
      checks++;
      if (op2 !== 8'd34 || alu_start !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL equals_launch: got op2=%0d start=%0b busy=%0b expected 34 1 1", op2, alu_start, busy);
      end
      alu_respond(3, 16'd46, 1'b0);
      checks++;
      if (disp_value !== 16'd46 || busy !== 1'b0 || disp_sign !== 1'b0) begin
         errors++; $display("FAIL add_result: got disp=%0d busy=%0b sign=%0b expected 46 0 0", disp_value, busy, disp_sign);
      end
      checks++;
      if (start_count - s0 !== 1) begin
         errors++; $display("FAIL start_pulse_count: got %0d expected 1", start_count - s0);
      end
      press(4'd12);
      checks++;
      if (op1 !== 8'd46 || operation !== 2'b10) begin
         errors++; $display("FAIL chain_op1: got op1=%0d op=%0d expected 46 2", op1, operation);
      end
      press(4'd2); press(4'd14);
      checks++;
      if (op2 !== 8'd2 || alu_start !== 1'b1) begin
         errors++; $display("FAIL chain_op2: got op2=%0d start=%0b expected 2 1", op2, alu_start);
      end
      alu_respond(0, 16'd92, 1'b0);
      press(4'd15);
      press(4'd3); press(4'd11); press(4'd9); press(4'd14);
      alu_respond(5, 16'd6, 1'b1);
      checks++;
      if (disp_value !== 16'd6 || disp_sign !== 1'b1) begin
         errors++; $display("FAIL negative_result: got disp=%0d sign=%0b expected 6 1", disp_value, disp_sign);
      end
      press(4'd10);
      checks++;
      if (disp_err !== 1'b1 || disp_value !== 16'd0) begin
         errors++; $display("FAIL negative_chain: got err=%0b disp=%0d expected 1 0", disp_err, disp_value);
      end
      press(4'd15);
      $display("test_basic_add_and_chain done");
   endtask

   task automatic test_overflow();
      press(4'd2); press(4'd5); press(4'd6);
      checks++;
      if (disp_value !== 16'd25 || disp_err !== 1'b0) begin
         errors++; $display("FAIL overflow_drop: got disp=%0d err=%0b expected 25 0", disp_value, disp_err);
      end
      press(4'd5);
      checks++;
      if (disp_value !== 16'd255) begin
         errors++; $display("FAIL max_operand: got %0d expected 255", disp_value);
      end
      press(4'd15);
      $display("test_overflow done");
   endtask

   task automatic test_div_zero();
      int s0;
      s0 = start_count;
      press(4'd9); press(4'd13); press(4'd0); press(4'd14);
      checks++;
      if (disp_err !== 1'b1 || busy !== 1'b0 || disp_value !== 16'd0) begin
         errors++; $display("FAIL div_zero: got err=%0b busy=%0b disp=%0d expected 1 0 0", disp_err, busy, disp_value);
      end
      press(4'd7);
      checks++;
      if (disp_err !== 1'b1 || disp_value !== 16'd0 || start_count !== s0) begin
         errors++; $display("FAIL error_hold: got err=%0b disp=%0d starts=%0d expected 1 0 %0d", disp_err, disp_value, start_count, s0);
      end
      press(4'd15);
      checks++;
      if ({op1, op2, operation, alu_start, disp_value, disp_sign, disp_err, busy} !== 37'd0) begin
         errors++; $display("FAIL clear_outputs: got op1=%0d op2=%0d op=%0d disp=%0d err=%0b expected all 0",
                            op1, op2, operation, disp_value, disp_err);
      end
      $display("test_div_zero done");
   endtask

   task automatic test_timeout();
      press(4'd5); press(4'd11); press(4'd7); press(4'd14);
      press(4'd7);
      checks++;
      if (disp_value !== 16'd7 || busy !== 1'b1 || op2 !== 8'd7) begin
         errors++; $display("FAIL exec_key_ignored: got disp=%0d busy=%0b op2=%0d expected 7 1 7", disp_value, busy, op2);
      end
      repeat (30) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1 || disp_err !== 1'b0) begin
         errors++; $display("FAIL timeout_early: got busy=%0b err=%0b expected 1 0", busy, disp_err);
      end
      @(posedge clk); #1;
      checks++;
      if (disp_err !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL timeout_error: got err=%0b busy=%0b expected 1 0", disp_err, busy);
      end
      press(4'd15);
      press(4'd5); press(4'd11); press(4'd7); press(4'd14);
      alu_respond(32, 16'd2, 1'b1);
      checks++;
      if (disp_err !== 1'b0 || disp_value !== 16'd2 || disp_sign !== 1'b1) begin
         errors++; $display("FAIL done_at_limit: got err=%0b disp=%0d sign=%0b expected 0 2 1", disp_err, disp_value, disp_sign);
      end
      press(4'd15);
      $display("test_timeout done");
   endtask

   task automatic test_abort_exec();
      int s0;
      press(4'd4); press(4'd10); press(4'd4); press(4'd14);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      s0 = start_count;
      alu_done = 1'b1; alu_result = 16'd8;
      @(posedge clk); #1;
      alu_done = 1'b0; alu_result = 16'd0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({op1, op2, operation, alu_start, disp_value, disp_sign, disp_err, busy} !== 37'd0 || start_count !== s0) begin
         errors++; $display("FAIL reset_in_exec: got op1=%0d op2=%0d disp=%0d busy=%0b starts=%0d expected all 0 starts=%0d",
                            op1, op2, disp_value, busy, start_count, s0);
      end
      press(4'd4); press(4'd10); press(4'd4); press(4'd14);
      @(posedge clk); #1;
      press(4'd15);
      alu_done = 1'b1; alu_result = 16'd8;
      @(posedge clk); #1;
      alu_done = 1'b0; alu_result = 16'd0;
      checks++;
      if (disp_value !== 16'd0 || busy !== 1'b0 || op1 !== 8'd0 || disp_err !== 1'b0) begin
         errors++; $display("FAIL clear_in_exec: got disp=%0d busy=%0b op1=%0d err=%0b expected 0 0 0 0", disp_value, busy, op1, disp_err);
      end
      press(4'd3);
      checks++;
      if (disp_value !== 16'd3) begin
         errors++; $display("FAIL after_abort_entry: got %0d expected 3", disp_value);
      end
      press(4'd15);
      $display("test_abort_exec done");
   endtask

   task automatic test_random();
      int k, r, delay;
      m_key(15);
      press(4'd15);
      for (int i = 0; i < 250; i++) begin
         r = $urandom_range(0, 99);
         if (r < 55)      k = $urandom_range(0, 9);
         else if (r < 78) k = $urandom_range(10, 13);
         else if (r < 94) k = 14;
         else             k = 15;
         if (m_phase == P_ERR && $urandom_range(0, 1) == 1) k = 15;
         press(4'(k));
         m_key(k);
         if (m_phase == P_EX) begin
            checks++;
            if (alu_start !== 1'b1 || busy !== 1'b1 || op1 !== 8'(m_op1) || op2 !== 8'(m_op2) || operation !== 2'(m_oper)) begin
               errors++;
               $display("FAIL rand_launch %0d: got start=%0b busy=%0b op1=%0d op2=%0d op=%0d expected 1 1 %0d %0d %0d",
                        i, alu_start, busy, op1, op2, operation, m_op1, m_op2, m_oper);
            end
            delay = $urandom_range(0, 36);
            if (delay <= 32) begin
               m_compute();
               alu_respond(delay, 16'(m_res), 1'(m_sign));
               m_phase = P_RES;
            end else begin
               repeat (33) @(posedge clk);
               #1;
               m_phase = P_ERR;
            end
         end else begin
            checks++;
            if (alu_start !== 1'b0) begin
               errors++; $display("FAIL rand_no_start %0d: got %0b expected 0", i, alu_start);
            end
         end
         checks++;
         if (disp_value !== 16'((m_phase == P_RES) ? m_res : (m_phase == P_ERR) ? 0 : m_acc) ||
             disp_sign !== ((m_phase == P_RES) && m_sign == 1) || disp_err !== (m_phase == P_ERR) ||
             busy !== 1'b0 || op1 !== 8'(m_op1) || op2 !== 8'(m_op2) || operation !== 2'(m_oper)) begin
            errors++;
            $display("FAIL rand_state %0d key=%0d: got disp=%0d sign=%0b err=%0b busy=%0b op1=%0d op2=%0d op=%0d expected phase=%0d acc=%0d res=%0d sign=%0d op1=%0d op2=%0d op=%0d",
                     i, k, disp_value, disp_sign, disp_err, busy, op1, op2, operation,
                     m_phase, m_acc, m_res, m_sign, m_op1, m_op2, m_oper);
         end
      end
      $display("test_random done");
   endtask

   initial begin
      test_reset();
      test_basic_add_and_chain();
      test_overflow();
      test_div_zero();
      test_timeout();
      test_abort_exec();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
